// File: rtl/lookahead_sample_sequencer_pkg.sv
// Shared types and constants for the lookahead sample sequencer: bank count,
// sequencer state encoding and circular bank arithmetic.
package lookahead_sample_sequencer_pkg;

  localparam int unsigned NUM_BANKS = 3;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t FILL = 2'd0;
  localparam seq_state_t WARM = 2'd1;
  localparam seq_state_t RUN  = 2'd2;

  // Bank index d positions behind b, modulo NUM_BANKS (d in 0..2).
  function automatic logic [1:0] bank_behind(input logic [1:0] b, input logic [1:0] d);
    logic [2:0] s;
    s = {1'b0, b} + 3'(NUM_BANKS) - {1'b0, d};
    if (s >= 3'(NUM_BANKS)) s = s - 3'(NUM_BANKS);
    return s[1:0];
  endfunction

endpackage

// File: rtl/lookahead_sample_sequencer_buffer.sv
// One-write, two-read synchronous RAM with registered read ports (1-cycle latency).
// Read registers update only on re, so read data holds across idle cycles.
module lookahead_sample_sequencer_buffer #(
  parameter int unsigned W     = 48,
  parameter int unsigned DEPTH = 192,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [W-1:0]  rdata_a,
  output logic [W-1:0]  rdata_b
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; only the read registers reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else if (re) begin
      rdata_a <= mem[raddr_a];
      rdata_b <= mem[raddr_b];
    end
  end

endmodule

// File: rtl/lookahead_sample_sequencer.sv
// Buffers downsampled control words in three banks and replays the two previous
// batches time-reversed, generating run/propagate/valid control for the recursion.
module lookahead_sample_sequencer
  import lookahead_sample_sequencer_pkg::*;
#(
  parameter int unsigned M   = 4,
  parameter int unsigned DSR = 12,
  parameter int unsigned L   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [M*DSR-1:0]   inSample,
  input  logic               validIn,
  output logic [M*DSR-1:0]   outSample,
  output logic [M*DSR-1:0]   lookaheadSample,
  output logic               validOut,
  output logic               propagate,
  output logic               recRun
);

  localparam int unsigned W     = M * DSR;
  localparam int unsigned DEPTH = NUM_BANKS * L;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(L);

  seq_state_t    state;
  logic [1:0]    wb;
  logic [CW-1:0] cnt;
  logic [CW-1:0] rcnt;
  logic          accept;
  logic          last_cnt;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr_la;
  logic [AW-1:0] raddr_cmp;

  // A word arriving with reset is dropped: reset wins.
  assign accept   = validIn && !rst;
  assign last_cnt = (cnt == CW'(L - 1));
  assign rcnt     = CW'(L - 1) - cnt;

  assign waddr     = AW'(wb) * AW'(L) + AW'(cnt);
  assign raddr_la  = AW'(bank_behind(wb, 2'd1)) * AW'(L) + AW'(rcnt);
  assign raddr_cmp = AW'(bank_behind(wb, 2'd2)) * AW'(L) + AW'(rcnt);

  lookahead_sample_sequencer_buffer #(
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buffer (
    .clk     (clk),
    .rst     (rst),
    .we      (accept),
    .waddr   (waddr),
    .wdata   (inSample),
    .re      (accept),
    .raddr_a (raddr_cmp),
    .raddr_b (raddr_la),
    .rdata_a (outSample),
    .rdata_b (lookaheadSample)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      wb        <= 2'd0;
      cnt       <= '0;
      validOut  <= 1'b0;
      propagate <= 1'b1;
      recRun    <= 1'b0;
    end else begin
      validOut  <= validIn && (state == RUN);
      propagate <= !(validIn && (state == RUN) && (cnt == '0));
      if (validIn && (state != FILL)) recRun <= 1'b1;

      if (validIn) begin
        if (last_cnt) begin
          cnt <= '0;
          wb  <= (wb == 2'd2) ? 2'd0 : wb + 2'd1;
          case (state)
            FILL:    state <= WARM;
            WARM:    state <= RUN;
            default: state <= RUN;
          endcase
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_lookahead_sample_sequencer.sv
// Scoreboard bench: a word-history reference model predicts each cycle's outputs,
// a separate monitor compares them against the DUT.
module tb_lookahead_sample_sequencer;

  localparam int unsigned M   = 4;
  localparam int unsigned DSR = 2;
  localparam int unsigned L   = 4;
  localparam int unsigned W   = M * DSR;

  typedef struct {
    logic [W-1:0] out_s;
    logic [W-1:0] la_s;
    bit           out_known;
    bit           la_known;
    bit           valid;
    bit           prop;
    bit           rec;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] inSample;
  logic         validIn;
  logic [W-1:0] outSample;
  logic [W-1:0] lookaheadSample;
  logic         validOut;
  logic         propagate;
  logic         recRun;

  int checks = 0;
  int errors = 0;

  exp_t         sb_q[$];
  logic [W-1:0] hist[$];
  exp_t         last_exp;
  logic [W-1:0] word_ctr;

  always #5 clk = ~clk;

  lookahead_sample_sequencer #(.M(M), .DSR(DSR), .L(L)) dut (
    .clk             (clk),
    .rst             (rst),
    .inSample        (inSample),
    .validIn         (validIn),
    .outSample       (outSample),
    .lookaheadSample (lookaheadSample),
    .validOut        (validOut),
    .propagate       (propagate),
    .recRun          (recRun)
  );

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  // Reference: word n since reset belongs to batch n/L at offset n%L; the streams
  // replay batches k-1 and k-2 at the mirrored offset.
  function automatic exp_t predict(input bit r, input bit v, input logic [W-1:0] d);
    exp_t e;
    int   n, k, j;
    e = last_exp;
    e.valid = 1'b0;
    e.prop  = 1'b1;
    if (r) begin
      hist.delete();
      e.out_s = '0; e.la_s = '0;
      e.out_known = 1'b1; e.la_known = 1'b1;
      e.rec = 1'b0;
    end else if (v) begin
      n = hist.size();
      k = n / L;
      j = n % L;
      e.la_known  = (k >= 1);
      e.out_known = (k >= 2);
      if (k >= 1) e.la_s  = hist[(k - 1) * L + (L - 1 - j)];
      if (k >= 2) e.out_s = hist[(k - 2) * L + (L - 1 - j)];
      e.valid = (k >= 2);
      e.prop  = !((k >= 2) && (j == 0));
      e.rec   = last_exp.rec || (k >= 1);
      hist.push_back(d);
    end
    return e;
  endfunction

  task automatic cycle(input bit r, input bit v, input logic [W-1:0] d);
    rst      = r;
    validIn  = v;
    inSample = d;
    @(posedge clk);
    #1;
    last_exp = predict(r, v, d);
    sb_q.push_back(last_exp);
  endtask

  task automatic next_word(input bit r);
    word_ctr = word_ctr + 1'b1;
    cycle(r, 1'b1, word_ctr);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("validOut", 64'(validOut), 64'(e.valid));
        check("propagate", 64'(propagate), 64'(e.prop));
        check("recRun", 64'(recRun), 64'(e.rec));
        if (e.out_known) check("outSample", 64'(outSample), 64'(e.out_s));
        if (e.la_known)  check("lookaheadSample", 64'(lookaheadSample), 64'(e.la_s));
      end
    end
  end

  initial begin : stimulus
    last_exp = '{out_s: '0, la_s: '0, out_known: 1'b0, la_known: 1'b0,
                 valid: 1'b0, prop: 1'b1, rec: 1'b0};
    word_ctr = '0;

    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 8'hAA);

    // Contiguous words 0x01..0x18 through FILL, WARM, RUN and a bank wrap.
    for (int i = 0; i < 24; i++) next_word(1'b0);

    // Gap after the second word of a batch, then resume.
    cycle(1'b1, 1'b0, '0);
    word_ctr = '0;
    for (int i = 0; i < 10; i++) next_word(1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h5A);
    for (int i = 0; i < 6; i++) next_word(1'b0);

    // Reset arriving with a valid word mid-run, then refill.
    cycle(1'b1, 1'b0, '0);
    word_ctr = '0;
    for (int i = 0; i < 9; i++) next_word(1'b0);
    next_word(1'b1);
    for (int i = 0; i < 12; i++) next_word(1'b0);

    // Randomized traffic with sparse gaps and occasional resets.
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(99) == 0, $urandom_range(3) != 0, W'($urandom));
    end

    cycle(1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #3;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
